// File: rtl/dpll_loop_nco.sv
// PI loop filter and phase-accumulator NCO that regenerates the PFD feedback clock,
// with a windowed activity-based lock detector.
module dpll_loop_nco #(
   parameter int unsigned ACC_W      = 16,
   parameter int unsigned CTRL_W     = 16,
   parameter int          FCW_CENTER = 4096,
   parameter int          FCW_MIN    = 1024,
   parameter int          FCW_MAX    = 16384,
   parameter int          KP_STEP    = 64,
   parameter int          KI_STEP    = 1,
   parameter int unsigned WIN        = 256,
   parameter int unsigned ACT_MAX    = 8,
   parameter int unsigned LOCK_WINS  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              up,
   input  logic              down,
   output logic              clk_fb,
   output logic [CTRL_W-1:0] fcw,
   output logic              rail,
   output logic              locked
);

   localparam int unsigned SW    = CTRL_W + 2;
   localparam int unsigned WIN_W = $clog2(WIN);
   localparam int unsigned ACT_W = $clog2(WIN + 1);
   localparam int unsigned QW    = $clog2(LOCK_WINS + 1);

   localparam logic [0:0] ACQUIRE = 1'b0;
   localparam logic [0:0] LOCKED  = 1'b1;

   localparam logic signed [SW-1:0] I_MIN = SW'(FCW_MIN - FCW_CENTER);
   localparam logic signed [SW-1:0] I_MAX = SW'(FCW_MAX - FCW_CENTER);
   localparam logic signed [SW-1:0] F_MIN = SW'(FCW_MIN);
   localparam logic signed [SW-1:0] F_MAX = SW'(FCW_MAX);
   localparam logic signed [SW-1:0] F_CTR = SW'(FCW_CENTER);
   localparam logic signed [SW-1:0] KI_S  = SW'(KI_STEP);
   localparam logic signed [SW-1:0] KP_S  = SW'(KP_STEP);

   logic signed [SW-1:0] integ_q, integ_d;
   logic [CTRL_W-1:0]    fcw_q, fcw_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic                 clk_fb_q, clk_fb_d;
   logic                 rail_q, rail_d;
   logic                 locked_q, locked_d;
   logic [0:0]           state_q, state_d;
   logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
   logic [ACT_W-1:0]     act_cnt_q, act_cnt_d;
   logic [QW-1:0]        quiet_q, quiet_d;

   logic signed [SW-1:0] ki_term, kp_term, integ_sum, fcw_sum, fcw_n;
   logic [ACT_W-1:0]     act_total;
   logic [QW-1:0]        quiet_inc;
   logic                 e_up, e_dn, integ_pin, fcw_oob, win_end, quiet;

   // Filter datapath, lock counters and next-state logic
   always_comb begin
      e_up      = up & ~down;
      e_dn      = down & ~up;
      ki_term   = e_up ? KI_S : (e_dn ? -KI_S : '0);
      kp_term   = e_up ? KP_S : (e_dn ? -KP_S : '0);
      integ_sum = integ_q + ki_term;

      integ_d = integ_sum;
      if (integ_sum < I_MIN) integ_d = I_MIN;
      if (integ_sum > I_MAX) integ_d = I_MAX;
      integ_pin = (integ_d == I_MIN) || (integ_d == I_MAX);

      fcw_sum = F_CTR + integ_d + kp_term;
      fcw_oob = (fcw_sum < F_MIN) || (fcw_sum > F_MAX);
      fcw_n   = fcw_sum;
      if (fcw_sum < F_MIN) fcw_n = F_MIN;
      if (fcw_sum > F_MAX) fcw_n = F_MAX;
      fcw_d   = CTRL_W'(fcw_n);
      rail_d  = fcw_oob | integ_pin;

      acc_d    = acc_q + ACC_W'(fcw_q);
      clk_fb_d = acc_q[ACC_W-1];

      win_end   = (win_cnt_q == WIN_W'(WIN - 1));
      act_total = act_cnt_q + ACT_W'(up | down);
      quiet     = (act_total <= ACT_W'(ACT_MAX));
      quiet_inc = (quiet_q == QW'(LOCK_WINS)) ? quiet_q : quiet_q + QW'(1);

      state_d   = state_q;
      quiet_d   = quiet_q;
      win_cnt_d = win_end ? '0 : win_cnt_q + WIN_W'(1);
      act_cnt_d = win_end ? '0 : act_total;

      if (win_end) begin
         case (state_q)
            ACQUIRE: begin
               if (quiet) begin
                  quiet_d = quiet_inc;
                  if (quiet_inc == QW'(LOCK_WINS)) state_d = LOCKED;
               end else begin
                  quiet_d = '0;
               end
            end
            LOCKED: begin
               if (!quiet) begin
                  state_d = ACQUIRE;
                  quiet_d = '0;
               end
            end
            default: state_d = ACQUIRE;
         endcase
      end

      // Open loop: park at centre frequency, restart acquisition from scratch
      if (!en) begin
         integ_d   = '0;
         fcw_d     = CTRL_W'(FCW_CENTER);
         rail_d    = 1'b0;
         state_d   = ACQUIRE;
         quiet_d   = '0;
         win_cnt_d = '0;
         act_cnt_d = '0;
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         integ_q   <= '0;
         fcw_q     <= CTRL_W'(FCW_CENTER);
         acc_q     <= '0;
         clk_fb_q  <= 1'b0;
         rail_q    <= 1'b0;
         locked_q  <= 1'b0;
         state_q   <= ACQUIRE;
         win_cnt_q <= '0;
         act_cnt_q <= '0;
         quiet_q   <= '0;
      end else begin
         integ_q   <= integ_d;
         fcw_q     <= fcw_d;
         acc_q     <= acc_d;
         clk_fb_q  <= clk_fb_d;
         rail_q    <= rail_d;
         locked_q  <= locked_d;
         state_q   <= state_d;
         win_cnt_q <= win_cnt_d;
         act_cnt_q <= act_cnt_d;
         quiet_q   <= quiet_d;
      end
   end

   assign clk_fb = clk_fb_q;
   assign fcw    = fcw_q;
   assign rail   = rail_q;
   assign locked = locked_q;

endmodule

// File: doc/dpll_loop_nco.md
Name: dpll_loop_nco

Overview:
- Digital loop filter plus numerically controlled oscillator. Consumes the clk-synchronous up/down error outputs of the phase frequency detector and regenerates the feedback clock clk_fb that drives that detector's feedback input.
- Proportional-integral filter produces a frequency control word (FCW). The FCW drives a phase accumulator whose MSB is clk_fb.
- Includes a windowed lock detector.

Parameters:
- ACC_W, 16, phase accumulator width (ACC_W >= CTRL_W).
- CTRL_W, 16, FCW width, unsigned.
- FCW_CENTER, 4096, free-running FCW (clk_fb = clk/16).
- FCW_MIN, 1024, lower FCW clamp.
- FCW_MAX, 16384, upper FCW clamp.
- KP_STEP, 64, proportional step per active cycle.
- KI_STEP, 1, integral step per active cycle.
- WIN, 256, lock window length in clk cycles.
- ACT_MAX, 8, max active (up|down) cycles per window still counted as quiet.
- LOCK_WINS, 4, consecutive quiet windows required to declare lock.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- en  in  1  loop enable; 0 = open loop at FCW_CENTER.
- up  in  1  PFD up: feedback lags, speed up.
- down  in  1  PFD down: feedback leads, slow down.
- clk_fb  out  1  regenerated feedback clock (registered accumulator MSB).
- fcw  out  CTRL_W  current frequency control word.
- rail  out  1  high while fcw is clamped at FCW_MIN or FCW_MAX.
- locked  out  1  lock indicator.

Behaviour:
- Reset (already decided): reset rst_n, asynchronous, active-low; clock clk.
- Reset values: fcw=FCW_CENTER, integ=0, acc=0, clk_fb=0, rail=0, locked=0, window/activity/quiet counters=0, FSM=ACQUIRE. Asserting rst_n mid-operation forces these values immediately.
- Error sample each cycle: e=+1 if up&!down; e=-1 if down&!up; e=0 otherwise, including both high.
- Integrator:
  - Signed, CTRL_W+2 bits.
  - integ_n = clamp(integ + e*KI_STEP, FCW_MIN-FCW_CENTER, FCW_MAX-FCW_CENTER).
  - Registered each cycle.
- FCW:
  - fcw_n = clamp(FCW_CENTER + integ_n + e*KP_STEP, FCW_MIN, FCW_MAX).
  - Computed in signed CTRL_W+2 arithmetic; registered.
  - Latency: up/down at cycle n is visible on fcw at n+1.
- rail: registered with fcw; 1 when the pre-clamp fcw sum lies outside [FCW_MIN, FCW_MAX], or integ_n sits on its clamp.
- Accumulator:
  - acc <= acc + fcw, wraps modulo 2^ACC_W, never stops.
  - clk_fb <= acc[ACC_W-1], giving one extra cycle of latency.
  - f_fb = f_clk * fcw / 2^ACC_W.
- en=0:
  - Next cycle: integ=0, fcw=FCW_CENTER, rail=0, FSM=ACQUIRE, locked=0, counters cleared.
  - up/down ignored; accumulator keeps running.
  - On en rising, the loop resumes from integ=0.
- Lock FSM, states ACQUIRE / LOCKED:
  - win_cnt counts 0..WIN-1 and wraps; counts only while en=1.
  - act_cnt accumulates (up|down) each cycle, including the window-end cycle itself.
  - At window end, the window is quiet if the total <= ACT_MAX. act_cnt then restarts at 0.
  - ACQUIRE, quiet window: quiet_cnt++. When quiet_cnt reaches LOCK_WINS, go to LOCKED.
  - ACQUIRE, non-quiet window: quiet_cnt=0.
  - LOCKED, non-quiet window: go to ACQUIRE and set quiet_cnt=0.
  - locked = (state==LOCKED), registered; it changes the cycle after the deciding window end.
  - quiet_cnt saturates at LOCK_WINS.
- Clamping is evaluated in wide arithmetic, with no wrap of intermediate sums.

Test Plan:
- Reset release, up=down=0, en=1 -> fcw=4096, clk_fb period exactly 16 clk (8 high/8 low) after a 2-cycle start-up, locked=0, rail=0.
- up=1 for 10 cycles, then 0 -> fcw=4161 after the 1st cycle, 4170 after the 10th, then 4106 one cycle after release (proportional term removed, integ=10 retained).
- down held 4000 cycles -> integ pins at -3072, fcw=1024, rail=1, clk_fb period 64 clk. Release -> fcw stays 1024 (integ -3072).
- en=1, up/down idle 1024 cycles -> locked rises the cycle after the 4th window end. Then a window with 9 single-cycle up pulses -> locked falls after that window end; with 8 pulses it stays 1.
- Integ at +50, en dropped -> next cycle fcw=4096, locked=0; up pulses during en=0 leave fcw at 4096.
- up=down=1 for 20 cycles -> fcw unchanged. Async rst_n pulse while LOCKED -> fcw=4096, locked=0, clk_fb=0 immediately, without waiting for a clk edge.
